// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, MSB-first, mid-bit sampling off a 2-flop synchronizer.
`timescale 1ns/100ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             rx,
    output logic [7:0]       data,
    output logic [CNT_W-1:0] realCounter
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic [1:0]       rx_pipe;   // [0] metastable stage, [1] usable rx_s
    logic             rx_s;

    assign rx_s        = rx_pipe[1];
    assign realCounter = cnt;

    // Two-flop synchronizer; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) rx_pipe <= 2'b11;
        else      rx_pipe <= {rx_pipe[0], rx};
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            data  <= data_n;
        end
    end

    // Next-state: half-bit wait to centre on the start bit, then full-bit steps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {shift[6:0], rx_s};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                // Stop-bit level is deliberately ignored; the byte is loaded regardless.
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    data_n  = shift;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random frames against a byte-level model of the receiver.
`timescale 1ns/100ps
module tb_uart_rx;

    localparam int CPB   = 434;
    localparam int CNT_W = 16;
    // Byte loads 4125 clocks after the first clock edge that sees the start edge
    // (2 sync + 1 idle + 217 half + 8*434 data + 434 stop - 1); probe either side.
    localparam int PRE_LOAD  = 4120;
    localparam int POST_LOAD = 4130;

    logic             clock;
    logic             clr;
    logic             rx;
    logic [7:0]       data;
    logic [CNT_W-1:0] realCounter;

    int         nvec;
    int         nerr;
    logic [7:0] exp_data;   // model: last byte whose frame has completed

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .clr         (clr),
        .rx          (rx),
        .data        (data),
        .realCounter (realCounter)
    );

    initial clock = 1'b0;
    always #1 clock = ~clock;

    // Counter must never exceed the last count of a bit period.
    always @(negedge clock) begin
        if (clr) begin
            nvec++;
            assert (realCounter <= CNT_W'(CPB - 1)) else begin
                nerr++;
                $error("FAIL cnt_bound observed=%0d required<=%0d", realCounter, CPB - 1);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 ns after a rising edge, the point where stimulus changes.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Full 10-bit frame; checks data just before and just after the load point.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] prev;
        prev = exp_data;
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_bit;
        wait_clks(PRE_LOAD - 9 * CPB);
        check("pre_load", {24'h0, data}, {24'h0, prev});
        wait_clks(POST_LOAD - PRE_LOAD);
        exp_data = b;
        check("post_load", {24'h0, data}, {24'h0, exp_data});
        wait_clks(10 * CPB - POST_LOAD);
    endtask

    initial begin
        logic [7:0] rb;
        int         gap;
        nvec = 0;
        nerr = 0;
        exp_data = 8'h00;
        clr = 1'b0;
        rx  = 1'b1;

        // Reset state, then counter parked at 0 while idle.
        #10;
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_cnt", {16'h0, realCounter}, 32'h0);
        @(posedge clock); #1;
        clr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            wait_clks(1);
            check("idle_cnt", {16'h0, realCounter}, 32'h0);
        end

        // Plain frame 0x9C.
        send_frame(8'h9C, 1'b1);

        // Low stop bit still loads the byte.
        send_frame(8'h9C, 1'b0);
        rx = 1'b1;
        wait_clks(2 * CPB);

        // Start-bit glitch shorter than half a bit is rejected.
        rx = 1'b0;
        wait_clks(100);
        check("glitch_cnt_run", {31'h0, realCounter != '0}, 32'h1);
        rx = 1'b1;
        wait_clks(300);
        check("glitch_data", {24'h0, data}, {24'h0, exp_data});
        check("glitch_cnt", {16'h0, realCounter}, 32'h0);

        // Back-to-back frames, no idle gap.
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);

        // Random bytes with random idle gaps.
        for (int k = 0; k < 6; k++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 40);
            wait_clks(gap);
            send_frame(rb, 1'b1);
        end
        wait_clks(20);
        check("idle_after_rand", {16'h0, realCounter}, 32'h0);

        // Asynchronous reset in the middle of DATA.
        rx = 1'b0;
        wait_clks(3 * CPB);
        check("mid_cnt_run", {31'h0, realCounter != '0}, 32'h1);
        clr = 1'b0;
        #0.5;
        exp_data = 8'h00;
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_cnt", {16'h0, realCounter}, 32'h0);
        wait_clks(1);
        rx = 1'b1;
        wait_clks(10);
        clr = 1'b1;
        wait_clks(CPB);
        send_frame(8'h81, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
